spram_arbiter: RTL
==================

SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 SHALL have parameter IDLE_TIMEOUT, default 64: consecutive idle cycles before the memory is put to sleep; 0 disables sleep.
REQ-002 SHALL have parameter WAKE_CYCLES, default 3: cycles mem_sleep must be low before the first access after wake; range 1..15.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have requester n = 0,1 ports: reqn_valid  in  1  request present; reqn_ready  out  1  request accepted this cycle; reqn_we  in  1  write when 1, read when 0.
REQ-005 SHALL have requester n = 0,1 ports: reqn_addr  in  14  word address; reqn_wdata  in  32  write data; reqn_wstrb  in  4  byte-write strobes.
REQ-006 SHALL have requester n = 0,1 ports: rspn_valid  out  1  read data valid; rspn_rdata  out  32  read data.
REQ-007 SHALL have memory ports: mem_addr  out  14; mem_wdata  out  32; mem_maskwren  out  8; mem_wren  out  1; mem_cs  out  1; mem_sleep  out  1; mem_rdata  in  32.

Function
REQ-008 SHALL implement states SLEEP, WAKE, READY, RDWAIT.
REQ-009 SHALL, in READY with any reqn_valid, grant exactly one requester, round-robin: on contention grant the port not granted most recently; after reset port 0 has priority.
REQ-010 SHALL assert reqn_ready combinationally only in the grant cycle, only in READY, only for the granted port.
REQ-011 SHALL, in the grant cycle, drive mem_cs=1, mem_addr=reqn_addr, mem_wdata=reqn_wdata, mem_wren=reqn_we.
REQ-012 SHALL drive mem_maskwren[2b+1:2b] = {2{reqn_wstrb[b]}} for b = 0..3 on writes, and 8'hFF on reads.
REQ-013 SHALL complete a write in the grant cycle and stay in READY; back-to-back writes are accepted every cycle.
REQ-014 SHALL, on a read grant, move to RDWAIT; in RDWAIT SHALL assert rspn_valid for the granted port for exactly one cycle, with rspn_rdata = mem_rdata; SHALL accept no request in RDWAIT; SHALL return to READY.
REQ-015 SHALL give read latency grant -> rsp_valid of exactly 1 cycle and read throughput of one read per 2 cycles.
REQ-016 SHALL drive mem_cs=0, mem_wren=0 and both reqn_ready=0 in all cycles without a grant.
REQ-017 SHALL count consecutive READY cycles with no reqn_valid (8-bit saturating idle counter); SHALL clear it on any valid.
REQ-018 SHALL, when the idle count reaches IDLE_TIMEOUT and IDLE_TIMEOUT != 0, enter SLEEP and assert mem_sleep=1.
REQ-019 SHALL, in SLEEP with any reqn_valid, deassert mem_sleep and enter WAKE.
REQ-020 SHALL hold WAKE for exactly WAKE_CYCLES cycles (4-bit counter), then enter READY; requests held valid are granted in the first READY cycle.
REQ-021 SHALL leave rspn_rdata unchanged except in a cycle where rspn_valid=1.
REQ-022 SHALL treat valid dropped before grant as withdrawn, with no memory access.

Reset
REQ-023 SHALL, on rst_n low, asynchronously force: state READY, mem_sleep 0, mem_cs 0, mem_wren 0, mem_maskwren 0, mem_addr 0, mem_wdata 0, rsp0_valid 0, rsp1_valid 0, rsp0_rdata 0, rsp1_rdata 0, idle and wake counters 0, round-robin pointer favouring port 0.
REQ-024 SHALL, when reset asserts during RDWAIT, produce no rsp_valid for that read.
REQ-025 SHALL deassert reset synchronously to clk through the existing reset path; this block adds no synchroniser.

Structure
REQ-026 SHALL keep the state encoding and the MASKWREN expansion constant in the shared processor package.
REQ-027 SHALL contain one sub-module, spram_rr_arbiter (2-port round-robin grant plus pointer); all other logic is flat.

Verification
REQ-028 SHALL have a bench case: req0 writes 0xDEADBEEF to addr 0x0010 with wstrb 4'hF, then req0 reads 0x0010 -> rsp0_valid one cycle after the read grant, rsp0_rdata = 0xDEADBEEF.
REQ-029 SHALL have a bench case: both ports hold reads of 0x0001 and 0x0002 -> grants alternate 0,1,0,1; each response appears on its own port only.
REQ-030 SHALL have a bench case: write with wstrb 4'b0100 -> mem_maskwren = 8'b00110000, mem_wren = 1, in the same cycle as req_ready.
REQ-031 SHALL have a bench case: 64 idle cycles -> mem_sleep=1; req1 valid -> mem_sleep=0 the next cycle; req1_ready exactly WAKE_CYCLES = 3 cycles later.
REQ-032 SHALL have a bench case: rst_n low in RDWAIT -> all outputs reach their reset values immediately; no rsp_valid occurs.
REQ-033 SHALL have a bench case: 8 back-to-back req0 writes -> req0_ready high on 8 consecutive cycles.

Source files
------------

// File: rtl/spram_arbiter_pkg.sv
// Shared types and constants for the two-port SPRAM arbiter.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package spram_arbiter_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int MASK_W = 8;

  typedef enum logic [1:0] {
    ST_SLEEP  = 2'd0,
    ST_WAKE   = 2'd1,
    ST_READY  = 2'd2,
    ST_RDWAIT = 2'd3
  } state_t;

  // Reads enable every nibble of the macro's write mask.
  localparam logic [MASK_W-1:0] MASKWREN_RD = 8'hFF;

  // Each byte strobe covers two nibble-mask bits of the SPRAM macro.
  function automatic logic [MASK_W-1:0] expand_wstrb(input logic [STRB_W-1:0] wstrb);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int b = 0; b < STRB_W; b++) begin
      m[2*b +: 2] = {2{wstrb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/spram_rr_arbiter.sv
// Two-port round-robin grant with a last-granted pointer.
// Latency: grant is combinational from requests; pointer updates on the clock after a grant.
// Backpressure: grants only while i_en is high; ungranted requesters simply wait.
module spram_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // Port most recently granted; starts at 1 so port 0 wins first contention.
  logic r_last;

  // Single requester wins outright; on contention the port not granted last wins.
  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) begin
        o_gnt = r_last ? 2'b01 : 2'b10;
      end else begin
        o_gnt = i_req;
      end
    end
  end

  // Remember which port was granted so the other gets the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (|o_gnt) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Two-port round-robin front end for a single-port SRAM with idle sleep and timed wake.
// Latency: writes complete in the grant cycle; read data returns exactly one cycle after grant.
// Backpressure: reqN_ready only in a READY grant cycle; requesters hold valid until ready.
module spram_arbiter
  import spram_arbiter_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 64,
  parameter int WAKE_CYCLES  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [STRB_W-1:0] req0_wstrb,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [STRB_W-1:0] req1_wstrb,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_maskwren,
  output logic              mem_wren,
  output logic              mem_cs,
  output logic              mem_sleep,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

  state_t            r_state;
  logic [7:0]        r_idle;
  logic [3:0]        r_wake;
  logic              r_rd_port;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  state_t            w_state_nxt;
  logic [7:0]        w_idle_nxt;
  logic [3:0]        w_wake_nxt;
  logic              w_rd_port_nxt;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_arb_en;
  logic              w_grant;
  logic              w_sel;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0] w_wstrb;
  logic              w_idle_hit;

  assign w_req = {req1_valid, req0_valid};
  // Gating with rst_n keeps every memory strobe low while reset is held.
  assign w_arb_en = rst_n && (r_state == ST_READY);

  spram_rr_arbiter u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_arb_en),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign w_grant    = |w_gnt;
  assign w_sel      = w_gnt[1];
  assign w_we       = w_sel ? req1_we    : req0_we;
  assign w_addr     = w_sel ? req1_addr  : req0_addr;
  assign w_wdata    = w_sel ? req1_wdata : req0_wdata;
  assign w_wstrb    = w_sel ? req1_wstrb : req0_wstrb;
  // This idle cycle is the one that reaches the timeout.
  assign w_idle_hit = (IDLE_TIMEOUT != 0) && ((32'(r_idle) + 32'd1) == 32'(IDLE_TIMEOUT));

  // Memory side is driven straight from the granted request; quiet otherwise.
  always_comb begin
    req0_ready   = w_gnt[0];
    req1_ready   = w_gnt[1];
    mem_cs       = w_grant;
    mem_wren     = w_grant && w_we;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_maskwren = '0;
    if (w_grant) begin
      mem_addr     = w_addr;
      mem_wdata    = w_wdata;
      mem_maskwren = w_we ? expand_wstrb(w_wstrb) : MASKWREN_RD;
    end
  end

  assign mem_sleep  = (r_state == ST_SLEEP);
  assign rsp0_valid = (r_state == ST_RDWAIT) && !r_rd_port;
  assign rsp1_valid = (r_state == ST_RDWAIT) &&  r_rd_port;
  // Response data passes through in its valid cycle and is held afterwards.
  assign rsp0_rdata = rsp0_valid ? mem_rdata : r_rdata0;
  assign rsp1_rdata = rsp1_valid ? mem_rdata : r_rdata1;

  // Next-state, idle counter and wake counter decisions.
  always_comb begin
    w_state_nxt   = r_state;
    w_idle_nxt    = r_idle;
    w_wake_nxt    = r_wake;
    w_rd_port_nxt = r_rd_port;
    case (r_state)
      ST_READY: begin
        if (w_grant) begin
          if (!w_we) begin
            w_state_nxt   = ST_RDWAIT;
            w_rd_port_nxt = w_sel;
          end
        end else if (w_idle_hit) begin
          w_state_nxt = ST_SLEEP;
          w_idle_nxt  = '0;
        end else if (r_idle != 8'hFF) begin
          w_idle_nxt = r_idle + 8'd1;
        end
      end
      ST_RDWAIT: begin
        w_state_nxt = ST_READY;
      end
      ST_SLEEP: begin
        if (|w_req) begin
          w_state_nxt = ST_WAKE;
          w_wake_nxt  = '0;
        end
      end
      ST_WAKE: begin
        if (r_wake == WAKE_LAST) begin
          w_state_nxt = ST_READY;
          w_wake_nxt  = '0;
        end else begin
          w_wake_nxt = r_wake + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_READY;
      end
    endcase
    if (|w_req) begin
      w_idle_nxt = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_READY;
      r_idle    <= '0;
      r_wake    <= '0;
      r_rd_port <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idle    <= w_idle_nxt;
      r_wake    <= w_wake_nxt;
      r_rd_port <= w_rd_port_nxt;
    end
  end

  // Capture read data so it stays stable after the response cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (rsp0_valid) r_rdata0 <= mem_rdata;
      if (rsp1_valid) r_rdata1 <= mem_rdata;
    end
  end

endmodule
